// File: rtl/cos_result_bcd.sv
// cos_result_bcd: cosine result word (value x 10^4) to sign + 5 BCD digits.
// Sequential double-dabble, one bit per clock, valid/ready on both sides.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   din, in_valid       result word from the cosine stage and its valid
//   in_ready            high only in IDLE; the block takes din on in_valid
//   sign                1 = result negative
//   bcd[19:0]           digit4 (MSD) in [19:16] ... digit0 in [3:0]
//   blank[4:0]          bit k = 1: digit k is a leading zero
//   dp_pos[2:0]         point sits left of digit dp_pos-1 (= FRAC_DIGITS)
//   out_valid/out_ready result handshake; outputs hold until taken
module cos_result_bcd #(
    parameter int SIGNED_IN   = 1,
    parameter int FRAC_DIGITS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] din,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        sign,
    output logic [19:0] bcd,
    output logic [4:0]  blank,
    output logic [2:0]  dp_pos,
    output logic        out_valid,
    input  logic        out_ready
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONV,
        S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        w_in_ready;
    logic        w_out_valid;
    logic        w_accept;
    logic        w_last;

    logic        r_sign;
    logic [19:0] r_bcd;
    logic [4:0]  r_blank;
    logic [15:0] r_mag;
    logic [3:0]  r_cnt;

    logic        w_sign;
    logic [15:0] w_mag;
    logic [19:0] w_adj;
    logic [19:0] w_shift;
    logic [4:0]  w_blank;
    logic        w_allz;

    assign w_accept = (r_state == S_IDLE) && in_valid;
    assign w_last   = (r_cnt == 4'd15);

    // Negative input is folded to its magnitude; 0x8000 maps to 32768.
    assign w_sign = (SIGNED_IN != 0) && din[15];
    assign w_mag  = w_sign ? (~din + 16'd1) : din;

    // Double-dabble step: pre-correct every digit >= 5, then shift in the
    // next magnitude bit.
    always_comb begin
        w_adj = '0;
        for (int k = 0; k < 5; k++) begin
            if (r_bcd[4*k +: 4] >= 4'd5) begin
                w_adj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
            end else begin
                w_adj[4*k +: 4] = r_bcd[4*k +: 4];
            end
        end
    end

    assign w_shift = {w_adj[18:0], r_mag[15]};

    // Scan from the MSD down; a digit is blank while everything above it
    // (and itself) is zero, but never at or below the units digit.
    always_comb begin
        w_blank = '0;
        w_allz  = 1'b1;
        for (int k = 4; k >= 0; k--) begin
            w_allz     = w_allz && (w_shift[4*k +: 4] == 4'd0);
            w_blank[k] = (k > FRAC_DIGITS) && w_allz;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_in_ready = 1'b1;
                if (in_valid) begin
                    w_next = S_CONV;
                end
            end
            S_CONV: begin
                if (w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_out_valid = 1'b1;
                if (out_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sign  <= 1'b0;
            r_bcd   <= '0;
            r_blank <= '0;
            r_mag   <= '0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_sign  <= w_sign;
            r_mag   <= w_mag;
            r_bcd   <= '0;
            r_blank <= '0;
            r_cnt   <= '0;
        end else if (r_state == S_CONV) begin
            r_bcd <= w_shift;
            r_mag <= {r_mag[14:0], 1'b0};
            r_cnt <= r_cnt + 4'd1;
            if (w_last) begin
                r_blank <= w_blank;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign sign      = r_sign;
    assign bcd       = r_bcd;
    assign blank     = r_blank;
    assign dp_pos    = 3'(FRAC_DIGITS);

endmodule

// File: tb/tb_cos_result_bcd.sv
// Bench for cos_result_bcd: three instances (signed/4, unsigned/4,
// signed/2), random + directed words, queue scoreboard with a monitor.
module tb_cos_result_bcd;

    typedef struct {
        int         inst;
        logic       sign;
        logic [19:0] bcd;
        logic [4:0] blank;
        logic [2:0] dp;
        int         acc;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [15:0] din       [3];
    logic        in_valid  [3];
    logic        in_ready  [3];
    logic        sign      [3];
    logic [19:0] bcd       [3];
    logic [4:0]  blank     [3];
    logic [2:0]  dp_pos    [3];
    logic        out_valid [3];
    logic        out_ready [3];

    exp_t sb[$];
    exp_t e;
    bit   prev_ov [3];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    for (genvar g = 0; g < 3; g++) begin : G
        cos_result_bcd #(
            .SIGNED_IN  (g == 1 ? 0 : 1),
            .FRAC_DIGITS(g == 2 ? 2 : 4)
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .din      (din[g]),
            .in_valid (in_valid[g]),
            .in_ready (in_ready[g]),
            .sign     (sign[g]),
            .bcd      (bcd[g]),
            .blank    (blank[g]),
            .dp_pos   (dp_pos[g]),
            .out_valid(out_valid[g]),
            .out_ready(out_ready[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exv);
        n_chk++;
        if (act !== exv) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", nm, act, exv);
        end
    endtask

    task automatic timeout(string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s: got timeout required response", nm);
    endtask

    // Reference: decimal digits by division, blanking by magnitude range.
    function automatic exp_t model(int i, logic [15:0] d);
        exp_t r;
        int   mag;
        int   fr;
        int   p;
        fr      = (i == 2) ? 2 : 4;
        r.inst  = i;
        r.sign  = (i != 1) && d[15];
        mag     = r.sign ? 65536 - int'(d) : int'(d);
        r.bcd   = '0;
        r.blank = '0;
        r.dp    = 3'(fr);
        r.acc   = 0;
        p       = 1;
        for (int k = 0; k < 5; k++) begin
            r.bcd[4*k +: 4] = 4'((mag / p) % 10);
            r.blank[k]      = (k > fr) && (mag < p);
            p               = p * 10;
        end
        return r;
    endfunction

    // Monitor: compares presented results against the queue head and
    // pops on handshake.
    always @(negedge clk) begin
        #2;
        for (int i = 0; i < 3; i++) begin
            if (out_valid[i]) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_out inst%0d: got bcd %h required none",
                             i, bcd[i]);
                end else begin
                    e = sb[0];
                    chk("inst", i, e.inst);
                    chk("sign", 32'(sign[i]), 32'(e.sign));
                    chk("bcd", 32'(bcd[i]), 32'(e.bcd));
                    chk("blank", 32'(blank[i]), 32'(e.blank));
                    chk("dp_pos", 32'(dp_pos[i]), 32'(e.dp));
                    chk("in_ready_done", 32'(in_ready[i]), 32'd0);
                    if (!prev_ov[i]) begin
                        chk("latency", cyc - e.acc - 1, 16);
                    end
                    if (out_ready[i]) begin
                        void'(sb.pop_front());
                    end
                end
            end
            prev_ov[i] = out_valid[i];
        end
    end

    task automatic run(int i, logic [15:0] d, int hold);
        int   t;
        exp_t x;
        @(negedge clk);
        out_ready[i] = (hold == 0);
        din[i]       = d;
        in_valid[i]  = 1'b1;
        t = 0;
        while (!in_ready[i] && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready[i]) begin
            timeout("accept");
            in_valid[i] = 1'b0;
            return;
        end
        x     = model(i, d);
        x.acc = cyc;
        sb.push_back(x);
        // Junk offered mid-conversion must not disturb the result.
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            in_valid[i] = 1'b1;
            din[i]      = 16'($urandom);
        end
        @(negedge clk);
        in_valid[i] = 1'b0;
        t = 0;
        while (!out_valid[i] && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (!out_valid[i]) begin
            timeout("out_valid");
            out_ready[i] = 1'b1;
            return;
        end
        for (int c = 0; c < hold; c++) begin
            in_valid[i] = (c < hold - 1);
            din[i]      = 16'($urandom);
            @(negedge clk);
        end
        out_ready[i] = 1'b1;
        @(negedge clk);
        chk("in_ready_after", 32'(in_ready[i]), 32'd1);
        chk("out_valid_after", 32'(out_valid[i]), 32'd0);
    endtask

    task automatic abort_test();
        @(negedge clk);
        din[0]      = 16'($urandom);
        in_valid[0] = 1'b1;
        @(negedge clk);
        in_valid[0] = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_in_ready", 32'(in_ready[0]), 32'd1);
        chk("rst_out_valid", 32'(out_valid[0]), 32'd0);
        chk("rst_bcd", 32'(bcd[0]), 32'd0);
        repeat (20) @(negedge clk);
        run(0, 16'd1234, 0);
    endtask

    initial begin
        int          t;
        int          i;
        logic [15:0] d;
        int          hold;
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            din[k]       = '0;
            in_valid[k]  = 1'b0;
            out_ready[k] = 1'b1;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("reset_in_ready", 32'(in_ready[k]), 32'd1);
            chk("reset_out_valid", 32'(out_valid[k]), 32'd0);
            chk("reset_sign", 32'(sign[k]), 32'd0);
            chk("reset_bcd", 32'(bcd[k]), 32'd0);
            chk("reset_blank", 32'(blank[k]), 32'd0);
        end

        run(0, 16'd10000, 0);
        run(0, 16'hEC78, 0);
        run(1, 16'hEC78, 0);
        run(0, 16'h8000, 0);
        run(1, 16'hFFFF, 0);
        run(2, 16'd7, 0);
        run(2, 16'd0, 0);
        run(0, 16'd0, 0);
        run(0, 16'hFFF9, 0);
        run(1, 16'd10000, 10);
        abort_test();

        for (int n = 0; n < 30; n++) begin
            i = n % 3;
            if ($urandom_range(0, 1) == 0) begin
                d = 16'($urandom);
            end else begin
                d = 16'($urandom_range(0, 150));
            end
            hold = ($urandom_range(0, 3) == 0) ? $urandom_range(3, 6) : 0;
            run(i, d, hold);
        end

        t = 0;
        while (sb.size() != 0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0) begin
            timeout("drain");
        end
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
